cmd_response_receiver: RTL and testbench
========================================

# cmd_response_receiver

Serial-to-parallel receive stage of the SD host CMD path, located directly downstream of `physic_block_control`. Once enabled, it watches the CMD pad for a card response start bit and shifts in a 48-bit response MSB-first. It then returns the parallel word to `physic_block_control` with a completion flag. If no start bit arrives within the response window, it raises a no-response flag instead.

## Interface
Parameters:
- `RESP_BITS`, 48: response frame length in bits.
- `TIMEOUT_CYCLES`, 64: maximum number of SD clock cycles to wait for a start bit (NCR).

Ports:
- `iClock_SD`  in  1  SD clock. All logic samples on its rising edge.
- `iReset`  in  1  reset; synchronous, active-high.
- `iEnable_STP`  in  1  receive enable from `physic_block_control`. Level, held for the whole transaction.
- `iCmd_in`  in  1  serial CMD pad input; idle-high.
- `oPad_response`  out  `RESP_BITS`  captured response; the first received bit lands at bit `RESP_BITS-1`.
- `oReception_complete`  out  1  the full frame has been captured.
- `oNo_response`  out  1  no start bit arrived within `TIMEOUT_CYCLES`.
- `oFrame_error`  out  1  the captured end bit is 0, or the transmission bit (bit `RESP_BITS-2`) is 1.
- `oCrc_error`  out  1  CRC7 mismatch. See Configuration.

## Operation
- States: IDLE, WAIT_START, RECEIVE, DONE, NORESP.
- IDLE:
  - All outputs are 0.
  - `iEnable_STP`=1 moves to WAIT_START and clears the wait counter.
- WAIT_START:
  - Samples `iCmd_in` every cycle. Sample indices run 0..`TIMEOUT_CYCLES-1`.
  - A sample of 0 is the start bit. It is shifted in as bit `RESP_BITS-1`, the bit counter is loaded with 1, and the FSM moves to RECEIVE.
  - If sample `TIMEOUT_CYCLES-1` is still 1, the FSM moves to NORESP.
  - A start bit on the final sample is accepted; the start bit wins over the timeout.
- RECEIVE:
  - Shifts `iCmd_in` in each cycle, left shift with the new bit at the LSB.
  - The bit counter increments each cycle.
  - When the counter reaches `RESP_BITS`, the FSM moves to DONE.
- DONE:
  - `oPad_response` is frozen.
  - `oReception_complete`=1.
  - `oFrame_error` and `oCrc_error` are evaluated on the frozen word.
  - Outputs are held until `iEnable_STP`=0.
- NORESP: `oNo_response`=1, held until `iEnable_STP`=0.
- `iEnable_STP`=0 in any state:
  - The FSM goes to IDLE on the next edge.
  - All outputs clear to 0, including `oPad_response`.
- `iCmd_in` is ignored in IDLE, DONE and NORESP.
- Counter widths:
  - Wait counter is `$clog2(TIMEOUT_CYCLES)`.
  - Bit counter is `$clog2(RESP_BITS+1)`.
  - Neither counter wraps, because the state exits before overflow.

## Timing
- Reset: on `iReset`=1 at an edge, the state becomes IDLE. All outputs and counters go to 0, and any capture in progress is discarded.
- Enable to first sample: if `iEnable_STP` rises before edge N, then edge N+1 takes sample 0.
- Start bit sampled at edge S:
  - The last data bit is sampled at edge S+`RESP_BITS-1`.
  - `oReception_complete` is high after edge S+`RESP_BITS`, i.e. 48 cycles after the start bit.
- Timeout:
  - `oNo_response` is high after the edge following sample `TIMEOUT_CYCLES-1`.
  - This is `TIMEOUT_CYCLES`+1 edges after entering WAIT_START.
- Flags are levels, not pulses. `physic_block_control` consumes them and then drops the enable.
- Enable drop: one cycle from `iEnable_STP` falling to all outputs reading 0.

## Configuration
- Macro `CMD_RX_CRC7_EN`.
- Defined:
  - Instantiates CRC7 (polynomial x^7+x^3+1, initial value 0).
  - CRC7 is fed bits `RESP_BITS-1` down to 8, serially during RECEIVE.
  - In DONE, `oCrc_error` = (computed CRC ≠ bits 7:1).
  - The CRC register clears on entry to WAIT_START.
- Undefined: `oCrc_error` is tied to 0 and no CRC logic is generated.

## Structure
- Shared package `sd_cmd_pkg` holds:
  - the state enum;
  - `SD_CMD_FRAME_BITS`=48;
  - `SD_NCR_MAX`=64;
  - `SD_CRC7_POLY`=7'h09.
- One sub-module, `cmd_crc7`: serial CRC7 with clock, sync clear, enable and data bit inputs and a 7-bit output. It is instantiated only under `CMD_RX_CRC7_EN`.

## Test plan
- Good response:
  - Stimulus: enable, 3 idle-high cycles, then frame 48'h3F_0000_0000_01 (with a valid CRC under the macro).
  - Expected: `oPad_response`=48'h3F00000001 and `oReception_complete`=1 exactly 48 cycles after the start bit; `oFrame_error`=0 and `oCrc_error`=0.
- Timeout:
  - Stimulus: enable with `iCmd_in` held at 1 for 70 cycles.
  - Expected: `oNo_response`=1 at cycle 65 after enable and stays 1; `oReception_complete`=0.
- Start bit on the last window sample:
  - Stimulus: start bit at sample 63.
  - Expected: capture proceeds and `oNo_response` stays 0.
- Framing error:
  - Stimulus: a frame with end bit 0.
  - Expected: `oFrame_error`=1 and `oReception_complete`=1.
  - With the macro defined, also corrupt bit 10 of a valid frame; expected `oCrc_error`=1.
- Abort:
  - Stimulus: drop `iEnable_STP` at bit 20 of a frame, then re-enable.
  - Expected: all outputs are 0 one cycle after the drop; the next frame is captured cleanly.
- Reset mid-capture:
  - Stimulus: assert `iReset` at bit 30.
  - Expected: all outputs are 0 after the next edge and the FSM is in IDLE.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// ----------------------------------------------------------------------------
// sd_cmd_pkg
// Shared definitions for the SD host CMD path: receive FSM state encoding,
// default frame length, NCR window and the CRC7 generator polynomial.
// ----------------------------------------------------------------------------
package sd_cmd_pkg;

    localparam int SD_CMD_FRAME_BITS = 48;
    localparam int SD_NCR_MAX        = 64;

    // x^7 + x^3 + 1, with the x^7 term implicit
    localparam logic [6:0] SD_CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_RECEIVE    = 3'd2,
        ST_DONE       = 3'd3,
        ST_NORESP     = 3'd4
    } rx_state_e;

endpackage : sd_cmd_pkg

// File: rtl/cmd_response_receiver_if.sv
// ----------------------------------------------------------------------------
// cmd_response_receiver_if
// Bundle between physic_block_control (master) and the CMD response
// receiver (slave).
//   iEnable_STP         master -> slave  receive enable, level for the txn
//   iCmd_in             pad    -> slave  serial CMD line, idle-high
//   oPad_response       slave  -> master captured frame, first bit at MSB
//   oReception_complete slave  -> master full frame captured
//   oNo_response        slave  -> master no start bit within the NCR window
//   oFrame_error        slave  -> master bad end bit or transmission bit
//   oCrc_error          slave  -> master CRC7 mismatch (0 when CRC disabled)
// ----------------------------------------------------------------------------
interface cmd_response_receiver_if
    import sd_cmd_pkg::*;
#(
    parameter int RESP_BITS = SD_CMD_FRAME_BITS
);
    logic                 iEnable_STP;
    logic                 iCmd_in;
    logic [RESP_BITS-1:0] oPad_response;
    logic                 oReception_complete;
    logic                 oNo_response;
    logic                 oFrame_error;
    logic                 oCrc_error;

    modport master (
        output iEnable_STP,
        output iCmd_in,
        input  oPad_response,
        input  oReception_complete,
        input  oNo_response,
        input  oFrame_error,
        input  oCrc_error
    );

    modport slave (
        input  iEnable_STP,
        input  iCmd_in,
        output oPad_response,
        output oReception_complete,
        output oNo_response,
        output oFrame_error,
        output oCrc_error
    );
endinterface : cmd_response_receiver_if

// File: rtl/cmd_crc7.sv
// ----------------------------------------------------------------------------
// cmd_crc7
// Serial CRC7 (x^7 + x^3 + 1, initial value 0), one bit per enabled cycle.
//   clk_i  clock (rising edge)
//   clr_i  synchronous clear to 0, dominates en_i
//   en_i   fold bit_i into the CRC this cycle
//   bit_i  serial data bit, MSB of the message first
//   crc_o  current CRC value
// ----------------------------------------------------------------------------
module cmd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);
    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       feedback;

    always_comb begin
        feedback = bit_i ^ crc_q[6];
        crc_d    = {crc_q[5:0], 1'b0} ^ (feedback ? SD_CRC7_POLY : 7'h00);
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            crc_q <= 7'h00;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;
endmodule : cmd_crc7

// File: rtl/cmd_response_receiver.sv
// ----------------------------------------------------------------------------
// cmd_response_receiver
// Serial-to-parallel receive stage of the SD host CMD path. When enabled it
// hunts for a start bit (0) on the CMD line within TIMEOUT_CYCLES samples,
// shifts in a RESP_BITS frame MSB-first and reports completion, no-response,
// framing and (optionally) CRC7 status as levels until the enable drops.
//   iClock_SD  SD clock, rising edge
//   iReset     synchronous active-high reset
//   rx         cmd_response_receiver_if.slave (enable, CMD line, results)
// Build option: define CMD_RX_CRC7_EN to check CRC7 over bits RESP_BITS-1..8
// against bits 7:1; otherwise oCrc_error is tied to 0.
// ----------------------------------------------------------------------------
module cmd_response_receiver
    import sd_cmd_pkg::*;
#(
    parameter int RESP_BITS      = SD_CMD_FRAME_BITS,
    parameter int TIMEOUT_CYCLES = SD_NCR_MAX
)(
    input logic                     iClock_SD,
    input logic                     iReset,
    cmd_response_receiver_if.slave  rx
);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
    localparam int BIT_W  = $clog2(RESP_BITS + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_FULL  = BIT_W'(RESP_BITS);

    rx_state_e            state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [RESP_BITS-1:0] shift_q, shift_d;
    logic                 complete_q, complete_d;
    logic                 noresp_q, noresp_d;
    logic                 frame_err_q, frame_err_d;
    logic                 crc_bad;

    // NOTE: every next-state variable gets a default before the case so no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        if (!rx.iEnable_STP) begin
            // Abort from any state; the shift register is cleared so the
            // parallel word reads 0 one cycle after the drop.
            state_d = ST_IDLE;
            wait_d  = '0;
            bit_d   = '0;
            shift_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_START;
                    wait_d  = '0;
                    bit_d   = '0;
                    shift_d = '0;
                end
                ST_WAIT_START: begin
                    // Start bit is checked first so it wins on the last sample.
                    if (!rx.iCmd_in) begin
                        shift_d = {shift_q[RESP_BITS-2:0], rx.iCmd_in};
                        bit_d   = BIT_W'(1);
                        state_d = ST_RECEIVE;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = ST_NORESP;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                ST_RECEIVE: begin
                    shift_d = {shift_q[RESP_BITS-2:0], rx.iCmd_in};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_d == BIT_FULL) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE, ST_NORESP: ;  // hold until the enable drops
                default: state_d = ST_IDLE;
            endcase
        end

        // Status flags are registered from the current state, so they appear
        // one edge after the state is entered and clear on the enable-drop edge.
        complete_d  = rx.iEnable_STP && (state_q == ST_DONE);
        noresp_d    = rx.iEnable_STP && (state_q == ST_NORESP);
        frame_err_d = complete_d && (!shift_q[0] || shift_q[RESP_BITS-2]);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge iClock_SD) begin
        if (iReset) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            complete_q  <= 1'b0;
            noresp_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            complete_q  <= complete_d;
            noresp_q    <= noresp_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef CMD_RX_CRC7_EN
    // Last bit fed to the CRC is bit 8, received when bit_q == RESP_BITS-9.
    localparam logic [BIT_W-1:0] BIT_CRC_LAST = BIT_W'(RESP_BITS - 9);

    logic       crc_clr;
    logic       crc_en;
    logic [6:0] crc_val;
    logic       crc_err_q;

    assign crc_clr = iReset || (rx.iEnable_STP && (state_q == ST_IDLE));
    assign crc_en  = rx.iEnable_STP &&
                     (((state_q == ST_WAIT_START) && !rx.iCmd_in) ||
                      ((state_q == ST_RECEIVE) && (bit_q <= BIT_CRC_LAST)));

    cmd_crc7 u_crc7 (
        .clk_i (iClock_SD),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .bit_i (rx.iCmd_in),
        .crc_o (crc_val)
    );

    always_ff @(posedge iClock_SD) begin
        if (iReset) begin
            crc_err_q <= 1'b0;
        end else begin
            crc_err_q <= complete_d && (crc_val != shift_q[7:1]);
        end
    end

    assign crc_bad = crc_err_q;
`else
    assign crc_bad = 1'b0;
`endif

    assign rx.oPad_response       = shift_q;
    assign rx.oReception_complete = complete_q;
    assign rx.oNo_response        = noresp_q;
    assign rx.oFrame_error        = frame_err_q;
    assign rx.oCrc_error          = crc_bad;
endmodule : cmd_response_receiver

// File: tb/tb_cmd_response_receiver.sv
// ----------------------------------------------------------------------------
// tb_cmd_response_receiver
// Directed bench for cmd_response_receiver: reset, good frame, timeout,
// start bit on the last window sample, framing/CRC errors, abort, and reset
// in the middle of a capture.
// ----------------------------------------------------------------------------
module tb_cmd_response_receiver;
    import sd_cmd_pkg::*;

    localparam int RB = SD_CMD_FRAME_BITS;

    logic iClock_SD = 1'b0;
    logic iReset;

    int n_checks = 0;
    int n_errors = 0;

    cmd_response_receiver_if #(.RESP_BITS(RB)) rx_if ();

    cmd_response_receiver #(
        .RESP_BITS      (RB),
        .TIMEOUT_CYCLES (SD_NCR_MAX)
    ) dut (
        .iClock_SD (iClock_SD),
        .iReset    (iReset),
        .rx        (rx_if.slave)
    );

    always #5 iClock_SD = ~iClock_SD;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs driven and outputs sampled here.
    task automatic tick();
        @(posedge iClock_SD);
        #1;
    endtask

    function automatic logic [6:0] crc7_model(input logic [39:0] msg);
        logic [6:0] c = 7'h00;
        logic       fb;
        for (int i = 39; i >= 0; i--) begin
            fb = msg[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] make_frame(input logic [39:0] hi, input logic end_bit);
        logic [6:0] crc;
`ifdef CMD_RX_CRC7_EN
        crc = crc7_model(hi);
`else
        crc = 7'h00;
`endif
        return {hi, crc, end_bit};
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "/pad"},   64'(rx_if.oPad_response),       64'h0);
        check({tag, "/cmpl"},  64'(rx_if.oReception_complete), 64'h0);
        check({tag, "/nores"}, 64'(rx_if.oNo_response),        64'h0);
        check({tag, "/ferr"},  64'(rx_if.oFrame_error),        64'h0);
        check({tag, "/crc"},   64'(rx_if.oCrc_error),          64'h0);
    endtask

    task automatic end_txn(input string tag);
        rx_if.iEnable_STP = 1'b0;
        rx_if.iCmd_in     = 1'b1;
        tick();
        check_zero({tag, "/drop"});
    endtask

    // Enable, idle_n high samples, then the frame; checks exact completion timing.
    task automatic receive_frame(input string tag, input logic [47:0] frame, input int idle_n,
                                 input logic exp_ferr, input logic exp_cerr);
        rx_if.iEnable_STP = 1'b1;
        rx_if.iCmd_in     = 1'b1;
        tick();                                   // enter WAIT_START
        for (int i = 0; i < idle_n; i++) tick();  // idle-high samples
        for (int b = RB - 1; b >= 0; b--) begin
            rx_if.iCmd_in = frame[b];
            tick();                               // start bit at edge S, last at S+47
        end
        check({tag, "/cmpl_early"}, 64'(rx_if.oReception_complete), 64'h0);
        rx_if.iCmd_in = 1'b1;
        tick();                                   // edge S+48
        check({tag, "/cmpl"},  64'(rx_if.oReception_complete), 64'h1);
        check({tag, "/pad"},   64'(rx_if.oPad_response),       64'(frame));
        check({tag, "/ferr"},  64'(rx_if.oFrame_error),        64'(exp_ferr));
        check({tag, "/crc"},   64'(rx_if.oCrc_error),          64'(exp_cerr));
        check({tag, "/nores"}, 64'(rx_if.oNo_response),        64'h0);
        rx_if.iCmd_in = 1'b0;                     // ignored in DONE
        tick();
        check({tag, "/hold"},  64'(rx_if.oReception_complete), 64'h1);
        check({tag, "/frz"},   64'(rx_if.oPad_response),       64'(frame));
        end_txn(tag);
    endtask

    logic [47:0] good;

    initial begin
        good = make_frame(40'h3F_0000_0000, 1'b1);

        rx_if.iEnable_STP = 1'b0;
        rx_if.iCmd_in     = 1'b1;
        iReset            = 1'b1;
        tick();
        tick();
        check_zero("reset");
        check("reset/state", 64'(dut.state_q), 64'(ST_IDLE));
        iReset = 1'b0;
        tick();
        check_zero("idle");

`ifndef CMD_RX_CRC7_EN
        check("good/const", 64'(good), 64'h3F_0000_0000_01);
`endif
        receive_frame("good", good, 3, 1'b0, 1'b0);

        // Timeout: WAIT_START entered at edge N, flag after edge N+65.
        rx_if.iEnable_STP = 1'b1;
        rx_if.iCmd_in     = 1'b1;
        tick();
        for (int i = 0; i < SD_NCR_MAX; i++) tick();
        check("to/early", 64'(rx_if.oNo_response), 64'h0);
        tick();
        check("to/flag", 64'(rx_if.oNo_response), 64'h1);
        for (int i = 0; i < 4; i++) tick();
        check("to/hold", 64'(rx_if.oNo_response),        64'h1);
        check("to/cmpl", 64'(rx_if.oReception_complete), 64'h0);
        end_txn("to");

        // Start bit on sample 63 is accepted.
        receive_frame("last", good, SD_NCR_MAX - 1, 1'b0, 1'b0);

        // Framing errors: end bit 0, then transmission bit 1.
        receive_frame("endbit", make_frame(40'h3F_0000_0000, 1'b0), 0, 1'b1, 1'b0);
        receive_frame("txbit",  make_frame(40'h7F_1234_5678, 1'b1), 5, 1'b1, 1'b0);
        receive_frame("data",   make_frame(40'h3A_DEAD_BEEF, 1'b1), 1, 1'b0, 1'b0);

`ifdef CMD_RX_CRC7_EN
        receive_frame("crcbad", good ^ (48'h1 << 10), 2, 1'b0, 1'b1);
`endif

        // Abort after 20 frame bits, then a clean capture.
        rx_if.iEnable_STP = 1'b1;
        rx_if.iCmd_in     = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            rx_if.iCmd_in = good[RB - 1 - i];
            tick();
        end
        rx_if.iEnable_STP = 1'b0;
        rx_if.iCmd_in     = 1'b1;
        tick();
        check_zero("abort");
        check("abort/state", 64'(dut.state_q), 64'(ST_IDLE));
        receive_frame("reabort", make_frame(40'h11_2233_4455, 1'b1), 2, 1'b0, 1'b0);

        // Reset after 30 frame bits.
        rx_if.iEnable_STP = 1'b1;
        rx_if.iCmd_in     = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) begin
            rx_if.iCmd_in = good[RB - 1 - i];
            tick();
        end
        iReset = 1'b1;
        tick();
        check_zero("rstmid");
        check("rstmid/state", 64'(dut.state_q), 64'(ST_IDLE));
        iReset            = 1'b0;
        rx_if.iEnable_STP = 1'b0;
        tick();
        receive_frame("postrst", good, 4, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule : tb_cmd_response_receiver
